// File: rtl/bk_sram_arbiter_if.sv
// Bus bundle between the BK-0010 SRAM arbiter and its requesters / SRAM pins.
// No logic of its own; the arbiter takes the slave side, the environment the master side.
// Backpressure: requests are levels held until the matching one-cycle ack.
interface bk_sram_arbiter_if #(
    parameter int ADDR_W = 18
);
    // CPU port (byte-addressed, word bus)
    logic              cpu_req;
    logic              cpu_we;
    logic [15:0]       cpu_adr;
    logic              cpu_byte;
    logic [15:0]       cpu_wdata;
    logic [15:0]       cpu_rdata;
    logic              cpu_ack;
    // Debug host port (word-addressed)
    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [15:0]       host_wdata;
    logic [15:0]       host_rdata;
    logic              host_ack;
    // Video shifter
    logic [12:0]       vid_addr;
    logic [15:0]       vid_data;
    logic              vid_load;
    logic [3:0]        phase;
    // SRAM pins
    logic [ADDR_W-1:0] ram_addr;
    logic [15:0]       ram_dq_o;
    logic              ram_dq_oe;
    logic [15:0]       ram_dq_i;
    logic              ram_oe_n;
    logic              ram_we_n;
    logic              ram_lb_n;
    logic              ram_ub_n;

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_adr, cpu_byte, cpu_wdata,
        input  host_req, host_we, host_addr, host_wdata,
        input  vid_addr, ram_dq_i,
        output cpu_rdata, cpu_ack, host_rdata, host_ack,
        output vid_data, vid_load, phase,
        output ram_addr, ram_dq_o, ram_dq_oe, ram_oe_n, ram_we_n, ram_lb_n, ram_ub_n
    );

    // Requester / SRAM side
    modport master (
        output cpu_req, cpu_we, cpu_adr, cpu_byte, cpu_wdata,
        output host_req, host_we, host_addr, host_wdata,
        output vid_addr, ram_dq_i,
        input  cpu_rdata, cpu_ack, host_rdata, host_ack,
        input  vid_data, vid_load, phase,
        input  ram_addr, ram_dq_o, ram_dq_oe, ram_oe_n, ram_we_n, ram_lb_n, ram_ub_n
    );
endinterface

// File: rtl/bk_sram_arbiter.sv
// Fixed 16-slot SRAM time-slot arbiter: video fetch at phase 0, CPU at 4-5, host at 8-9 and 12-13.
// Latency: video word at phase 1, CPU ack at phase 6, host ack at phase 10/14 (2 cycles from slot start).
// Backpressure: level requests sampled at slot start, held until a one-cycle ack; no queuing.
module bk_sram_arbiter #(
    parameter logic [4:0] VIDEO_BASE = 5'b00001,
    parameter int         ADDR_W     = 18
) (
    input logic              clk25,
    input logic              reset_n,
    bk_sram_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VID,
        S_CPU_SETUP,
        S_CPU_STROBE,
        S_HOST_SETUP,
        S_HOST_STROBE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_phase;
    logic [3:0]        w_phase_nxt;

    logic [ADDR_W-1:0] w_vid_word;
    logic [ADDR_W-1:0] w_cpu_word;
    logic              w_cpu_lb_n;
    logic              w_cpu_ub_n;

    logic [ADDR_W-1:0] w_addr_nxt;
    logic [15:0]       w_dq_nxt;
    logic              w_dq_oe_nxt;
    logic              w_oe_n_nxt;
    logic              w_we_n_nxt;
    logic              w_lb_n_nxt;
    logic              w_ub_n_nxt;

    logic [ADDR_W-1:0] r_ram_addr;
    logic [15:0]       r_dq_o;
    logic              r_dq_oe;
    logic              r_oe_n;
    logic              r_we_n;
    logic              r_lb_n;
    logic              r_ub_n;

    logic [15:0]       r_vid_data;
    logic              r_vid_load;
    logic [15:0]       r_cpu_rdata;
    logic              r_cpu_ack;
    logic [15:0]       r_host_rdata;
    logic              r_host_ack;

    assign w_phase_nxt = r_phase + 4'd1;
    assign w_vid_word  = ADDR_W'({VIDEO_BASE, bus.vid_addr});
    assign w_cpu_word  = ADDR_W'(bus.cpu_adr[15:1]);
    // Byte access disables the lane not addressed by bit 0; word access enables both.
    assign w_cpu_lb_n  = bus.cpu_byte &  bus.cpu_adr[0];
    assign w_cpu_ub_n  = bus.cpu_byte & ~bus.cpu_adr[0];

    // Phase counter and slot state register.
    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
            r_phase <= 4'd0;
            r_state <= S_IDLE;
        end else begin
            r_phase <= w_phase_nxt;
            r_state <= w_state_nxt;
        end
    end

    // Next slot from the upcoming phase and requests, then the pin values that slot needs.
    always_comb begin
        w_state_nxt = S_IDLE;
        case (w_phase_nxt)
            4'd0:        w_state_nxt = S_VID;
            4'd4:        if (bus.cpu_req) w_state_nxt = S_CPU_SETUP;
            4'd5:        if (r_state == S_CPU_SETUP) w_state_nxt = S_CPU_STROBE;
            4'd8, 4'd12: if (bus.host_req) w_state_nxt = S_HOST_SETUP;
            4'd9, 4'd13: if (r_state == S_HOST_SETUP) w_state_nxt = S_HOST_STROBE;
            default:     w_state_nxt = S_IDLE;
        endcase

        w_addr_nxt  = w_vid_word;
        w_dq_nxt    = 16'h0000;
        w_dq_oe_nxt = 1'b0;
        w_oe_n_nxt  = 1'b1;
        w_we_n_nxt  = 1'b1;
        w_lb_n_nxt  = 1'b1;
        w_ub_n_nxt  = 1'b1;
        case (w_state_nxt)
            S_VID: begin
                w_oe_n_nxt = 1'b0;
                w_lb_n_nxt = 1'b0;
                w_ub_n_nxt = 1'b0;
            end
            S_CPU_SETUP, S_CPU_STROBE: begin
                w_addr_nxt = w_cpu_word;
                w_lb_n_nxt = w_cpu_lb_n;
                w_ub_n_nxt = w_cpu_ub_n;
                if (bus.cpu_we) begin
                    w_dq_oe_nxt = 1'b1;
                    w_dq_nxt    = bus.cpu_wdata;
                    // WE only in the second cycle so address/data settle first.
                    w_we_n_nxt  = (w_state_nxt != S_CPU_STROBE);
                end else begin
                    w_oe_n_nxt  = 1'b0;
                end
            end
            S_HOST_SETUP, S_HOST_STROBE: begin
                w_addr_nxt = bus.host_addr;
                w_lb_n_nxt = 1'b0;
                w_ub_n_nxt = 1'b0;
                if (bus.host_we) begin
                    w_dq_oe_nxt = 1'b1;
                    w_dq_nxt    = bus.host_wdata;
                    w_we_n_nxt  = (w_state_nxt != S_HOST_STROBE);
                end else begin
                    w_oe_n_nxt  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Registered SRAM pins; reset forces every strobe inactive immediately.
    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
            r_ram_addr <= ADDR_W'({VIDEO_BASE, 13'd0});
            r_dq_o     <= 16'h0000;
            r_dq_oe    <= 1'b0;
            r_oe_n     <= 1'b1;
            r_we_n     <= 1'b1;
            r_lb_n     <= 1'b1;
            r_ub_n     <= 1'b1;
        end else begin
            r_ram_addr <= w_addr_nxt;
            r_dq_o     <= w_dq_nxt;
            r_dq_oe    <= w_dq_oe_nxt;
            r_oe_n     <= w_oe_n_nxt;
            r_we_n     <= w_we_n_nxt;
            r_lb_n     <= w_lb_n_nxt;
            r_ub_n     <= w_ub_n_nxt;
        end
    end

    // Capture read data at the end of each read slot and pulse the owner's ack/load.
    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
            r_vid_data   <= 16'h0000;
            r_vid_load   <= 1'b0;
            r_cpu_rdata  <= 16'h0000;
            r_cpu_ack    <= 1'b0;
            r_host_rdata <= 16'h0000;
            r_host_ack   <= 1'b0;
        end else begin
            r_vid_load <= (r_state == S_VID);
            if (r_state == S_VID) r_vid_data <= bus.ram_dq_i;
            r_cpu_ack <= (r_state == S_CPU_STROBE);
            if (r_state == S_CPU_STROBE && !bus.cpu_we) r_cpu_rdata <= bus.ram_dq_i;
            r_host_ack <= (r_state == S_HOST_STROBE);
            if (r_state == S_HOST_STROBE && !bus.host_we) r_host_rdata <= bus.ram_dq_i;
        end
    end

    assign bus.phase      = r_phase;
    assign bus.ram_addr   = r_ram_addr;
    assign bus.ram_dq_o   = r_dq_o;
    assign bus.ram_dq_oe  = r_dq_oe;
    assign bus.ram_oe_n   = r_oe_n;
    assign bus.ram_we_n   = r_we_n;
    assign bus.ram_lb_n   = r_lb_n;
    assign bus.ram_ub_n   = r_ub_n;
    assign bus.vid_data   = r_vid_data;
    assign bus.vid_load   = r_vid_load;
    assign bus.cpu_rdata  = r_cpu_rdata;
    assign bus.cpu_ack    = r_cpu_ack;
    assign bus.host_rdata = r_host_rdata;
    assign bus.host_ack   = r_host_ack;

endmodule

// File: tb/tb_bk_sram_arbiter.sv
// Bench for bk_sram_arbiter: SRAM pin model, slot-level reference model, per-cycle compare.
// Directed scenarios pin the model with literal values, then randomized requests run long.
// Requests are held until ack, fields change only when idle or at ack.
module tb_bk_sram_arbiter;
    localparam int         AW = 18;
    localparam logic [4:0] VB = 5'b00001;

    logic clk25   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk25 = ~clk25;

    bk_sram_arbiter_if #(.ADDR_W(AW)) bus();

    bk_sram_arbiter #(.VIDEO_BASE(VB), .ADDR_W(AW)) dut (
        .clk25  (clk25),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timed out at %0t", nm, $time);
    endtask

    // Power-up contents of every word; 0x04000 holds the CPU-read test pattern.
    function automatic logic [15:0] init_word(input logic [AW-1:0] a);
        if (a == 18'h04000) return 16'h1234;
        return 16'(a[15:0] * 16'h9E37) ^ {14'h0, a[17:16]} ^ 16'h5A3C;
    endfunction

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                          input logic lb_n, input logic ub_n);
        return {ub_n ? old[15:8] : d[15:8], lb_n ? old[7:0] : d[7:0]};
    endfunction

    // SRAM driven purely by the DUT pins.
    bit [15:0] sram   [0:(1<<AW)-1];
    bit        sram_v [0:(1<<AW)-1];
    function automatic logic [15:0] sram_rd(input logic [AW-1:0] a);
        return sram_v[a] ? sram[a] : init_word(a);
    endfunction
    assign bus.ram_dq_i = bus.ram_oe_n ? 16'h0000 : sram_rd(bus.ram_addr);
    always @(posedge clk25) begin
        if (!bus.ram_we_n) begin
            sram[bus.ram_addr]   <= merge(sram_rd(bus.ram_addr),
                                          bus.ram_dq_oe ? bus.ram_dq_o : 16'hDEAD,
                                          bus.ram_lb_n, bus.ram_ub_n);
            sram_v[bus.ram_addr] <= 1'b1;
        end
    end

    // Reference memory updated from the model's own view of completed writes.
    bit [15:0] shd   [0:(1<<AW)-1];
    bit        shd_v [0:(1<<AW)-1];
    function automatic logic [15:0] shd_rd(input logic [AW-1:0] a);
        return shd_v[a] ? shd[a] : init_word(a);
    endfunction

    // Slot-level model: which requester owns the frame position and what it latched at slot start.
    logic [3:0]    m_phase;
    logic [12:0]   m_vaddr;
    logic          m_vid;
    logic          m_cpu, m_cwe, m_cbyte;
    logic [15:0]   m_cadr, m_cwd;
    logic          m_host, m_hwe;
    logic [AW-1:0] m_hadr;
    logic [15:0]   m_hwd;
    logic          e_cack, e_hack, e_vload;
    logic [15:0]   e_crd, e_hrd, e_vdata;

    always @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
            m_phase <= 4'd0; m_vaddr <= 13'd0; m_vid <= 1'b0;
            m_cpu <= 1'b0; m_cwe <= 1'b0; m_cbyte <= 1'b0; m_cadr <= 16'd0; m_cwd <= 16'd0;
            m_host <= 1'b0; m_hwe <= 1'b0; m_hadr <= '0; m_hwd <= 16'd0;
            e_cack <= 1'b0; e_hack <= 1'b0; e_vload <= 1'b0;
            e_crd <= 16'd0; e_hrd <= 16'd0; e_vdata <= 16'd0;
        end else begin
            m_phase <= m_phase + 4'd1;
            m_vaddr <= bus.vid_addr;
            m_vid   <= (m_phase == 4'd15);
            e_vload <= m_vid;
            if (m_vid) e_vdata <= shd_rd({VB, m_vaddr});

            if (m_phase == 4'd3) begin
                m_cpu <= bus.cpu_req; m_cwe <= bus.cpu_we; m_cbyte <= bus.cpu_byte;
                m_cadr <= bus.cpu_adr; m_cwd <= bus.cpu_wdata;
            end else if (m_phase == 4'd5) begin
                m_cpu <= 1'b0;
            end
            e_cack <= m_cpu && m_phase == 4'd5;
            if (m_cpu && m_phase == 4'd5) begin
                if (m_cwe) begin
                    shd[AW'(m_cadr[15:1])]   <= merge(shd_rd(AW'(m_cadr[15:1])), m_cwd,
                                                      m_cbyte & m_cadr[0], m_cbyte & ~m_cadr[0]);
                    shd_v[AW'(m_cadr[15:1])] <= 1'b1;
                end else begin
                    e_crd <= shd_rd(AW'(m_cadr[15:1]));
                end
            end

            if (m_phase == 4'd7 || m_phase == 4'd11) begin
                m_host <= bus.host_req; m_hwe <= bus.host_we;
                m_hadr <= bus.host_addr; m_hwd <= bus.host_wdata;
            end else if (m_phase == 4'd9 || m_phase == 4'd13) begin
                m_host <= 1'b0;
            end
            e_hack <= m_host && (m_phase == 4'd9 || m_phase == 4'd13);
            if (m_host && (m_phase == 4'd9 || m_phase == 4'd13)) begin
                if (m_hwe) begin
                    shd[m_hadr]   <= m_hwd;
                    shd_v[m_hadr] <= 1'b1;
                end else begin
                    e_hrd <= shd_rd(m_hadr);
                end
            end
        end
    end

    task automatic compare_cycle();
        logic [AW-1:0] ea;
        logic          eoe, ewe, elb, eub, edqoe;
        logic [15:0]   edq;
        ea = {VB, m_vaddr}; eoe = 1'b1; ewe = 1'b1; elb = 1'b1; eub = 1'b1; edqoe = 1'b0; edq = 16'h0;
        if (m_vid && m_phase == 4'd0) begin
            eoe = 1'b0; elb = 1'b0; eub = 1'b0;
        end else if (m_cpu && (m_phase == 4'd4 || m_phase == 4'd5)) begin
            ea  = AW'(m_cadr[15:1]);
            elb = m_cbyte & m_cadr[0];
            eub = m_cbyte & ~m_cadr[0];
            if (m_cwe) begin edqoe = 1'b1; edq = m_cwd; ewe = (m_phase != 4'd5); end
            else eoe = 1'b0;
        end else if (m_host && (m_phase == 4'd8 || m_phase == 4'd9 ||
                                m_phase == 4'd12 || m_phase == 4'd13)) begin
            ea = m_hadr; elb = 1'b0; eub = 1'b0;
            if (m_hwe) begin edqoe = 1'b1; edq = m_hwd; ewe = (m_phase != 4'd9 && m_phase != 4'd13); end
            else eoe = 1'b0;
        end
        chk("phase",      32'(bus.phase),      32'(m_phase));
        chk("ram_addr",   32'(bus.ram_addr),   32'(ea));
        chk("ram_oe_n",   32'(bus.ram_oe_n),   32'(eoe));
        chk("ram_we_n",   32'(bus.ram_we_n),   32'(ewe));
        chk("ram_lb_n",   32'(bus.ram_lb_n),   32'(elb));
        chk("ram_ub_n",   32'(bus.ram_ub_n),   32'(eub));
        chk("ram_dq_oe",  32'(bus.ram_dq_oe),  32'(edqoe));
        if (edqoe) chk("ram_dq_o", 32'(bus.ram_dq_o), 32'(edq));
        chk("cpu_ack",    32'(bus.cpu_ack),    32'(e_cack));
        chk("cpu_rdata",  32'(bus.cpu_rdata),  32'(e_crd));
        chk("host_ack",   32'(bus.host_ack),   32'(e_hack));
        chk("host_rdata", 32'(bus.host_rdata), 32'(e_hrd));
        chk("vid_load",   32'(bus.vid_load),   32'(e_vload));
        chk("vid_data",   32'(bus.vid_data),   32'(e_vdata));
    endtask

    initial forever begin
        @(negedge clk25);
        compare_cycle();
    end

    task automatic wait_phase(input logic [3:0] p);
        bit found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk25);
            if (bus.phase == p) found = 1'b1;
        end
        if (!found) timeout("wait_phase");
    endtask

    // One CPU access launched at phase 2; snapshots the pins of the slot and returns the ack phase.
    task automatic cpu_access(input logic we, input logic [15:0] adr, input logic byt,
                              input logic [15:0] wd, output int ack_ph,
                              output logic [AW-1:0] a4, output logic we4, output logic we5,
                              output logic lb5, output logic ub5, output logic oe5);
        a4 = '0; we4 = 1'b0; we5 = 1'b1; lb5 = 1'b0; ub5 = 1'b0; oe5 = 1'b1;
        ack_ph = -1;
        wait_phase(4'd2);
        bus.cpu_we = we; bus.cpu_adr = adr; bus.cpu_byte = byt; bus.cpu_wdata = wd;
        bus.cpu_req = 1'b1;
        for (int i = 0; i < 24 && ack_ph < 0; i++) begin
            @(negedge clk25);
            if (bus.phase == 4'd4) begin a4 = bus.ram_addr; we4 = bus.ram_we_n; end
            if (bus.phase == 4'd5) begin
                we5 = bus.ram_we_n; lb5 = bus.ram_lb_n; ub5 = bus.ram_ub_n; oe5 = bus.ram_oe_n;
            end
            if (bus.cpu_ack) begin ack_ph = int'(bus.phase); bus.cpu_req = 1'b0; end
        end
        if (ack_ph < 0) timeout("cpu_access");
    endtask

    task automatic rand_cpu();
        bus.cpu_we    = 1'($urandom_range(0, 1));
        bus.cpu_adr   = 16'($urandom_range(0, 63));
        bus.cpu_byte  = 1'($urandom_range(0, 1));
        bus.cpu_wdata = 16'($urandom);
    endtask

    task automatic rand_host();
        bus.host_we    = 1'($urandom_range(0, 1));
        bus.host_addr  = $urandom_range(0, 1) ? AW'($urandom_range(0, 31))
                                              : (18'h02000 | AW'($urandom_range(0, 7)));
        bus.host_wdata = 16'($urandom);
    endtask

    initial begin
        int            ack_ph, n_c, n_h, n_ack;
        logic [AW-1:0] a4;
        logic          we4, we5, lb5, ub5, oe5;
        logic [15:0]   w;
        logic [AW-1:0] va;

        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_adr = 16'h0; bus.cpu_byte = 1'b0;
        bus.cpu_wdata = 16'h0; bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0;
        bus.host_wdata = 16'h0; bus.vid_addr = 13'h0ABC;

        // Reset state
        repeat (3) @(negedge clk25);
        chk("rst_phase",     32'(bus.phase),     32'd0);
        chk("rst_oe_n",      32'(bus.ram_oe_n),  32'd1);
        chk("rst_we_n",      32'(bus.ram_we_n),  32'd1);
        chk("rst_lanes",     32'({bus.ram_lb_n, bus.ram_ub_n}), 32'd3);
        chk("rst_dq_oe",     32'(bus.ram_dq_oe), 32'd0);
        chk("rst_acks",      32'({bus.cpu_ack, bus.host_ack, bus.vid_load}), 32'd0);
        chk("rst_data",      32'(bus.cpu_rdata | bus.host_rdata | bus.vid_data), 32'd0);

        // Free-running phase, video fetch in phase 0, load strobe in phase 1
        reset_n = 1'b1;
        va = {VB, 13'h0ABC};
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk25);
            chk("phase_count", 32'(bus.phase), 32'(k % 16));
            if (k <= 16) chk("oe_only_phase0", 32'(bus.ram_oe_n), (k == 16) ? 32'd0 : 32'd1);
            if (k == 17) begin
                chk("vid_load_ph1", 32'(bus.vid_load), 32'd1);
                chk("vid_data_ph1", 32'(bus.vid_data), 32'(init_word(va)));
            end
        end

        // CPU word read of octal 100000
        cpu_access(1'b0, 16'o100000, 1'b0, 16'h0, ack_ph, a4, we4, we5, lb5, ub5, oe5);
        chk("rd_ack_phase", 32'(ack_ph), 32'd6);
        chk("rd_addr_ph4",  32'(a4), 32'h04000);
        chk("rd_oe_ph5",    32'(oe5), 32'd0);
        chk("rd_data",      32'(bus.cpu_rdata), 32'h1234);

        // CPU byte write to odd address: only the upper lane is written
        cpu_access(1'b1, 16'h0101, 1'b1, 16'h00AB, ack_ph, a4, we4, we5, lb5, ub5, oe5);
        chk("bw_ack_phase", 32'(ack_ph), 32'd6);
        chk("bw_we_ph4",    32'(we4), 32'd1);
        chk("bw_we_ph5",    32'(we5), 32'd0);
        chk("bw_lb_n",      32'(lb5), 32'd1);
        chk("bw_ub_n",      32'(ub5), 32'd0);
        w = sram_rd(18'h00080);
        chk("bw_upper",     32'(w[15:8]), 32'h00);
        va = 18'h00080;
        w = init_word(va) ^ sram_rd(18'h00080);
        chk("bw_lower_kept", 32'(w[7:0]), 32'h00);

        // CPU and host in the same frame; host writes then reads back
        wait_phase(4'd2);
        bus.cpu_we = 1'b0; bus.cpu_adr = 16'h0040; bus.cpu_byte = 1'b0; bus.cpu_req = 1'b1;
        bus.host_we = 1'b1; bus.host_addr = 18'h08000; bus.host_wdata = 16'hBEEF; bus.host_req = 1'b1;
        n_c = 0; n_h = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk25);
            if (bus.cpu_ack) begin
                n_c++;
                chk("mix_cpu_phase", 32'(bus.phase), 32'd6);
                bus.cpu_req = 1'b0;
            end
            if (bus.host_ack) begin
                n_h++;
                if (n_h == 1) begin
                    chk("mix_hwr_phase", 32'(bus.phase), 32'd10);
                    bus.host_we = 1'b0;
                end else begin
                    chk("mix_hrd_phase", 32'(bus.phase), 32'd14);
                    chk("mix_hrd_data",  32'(bus.host_rdata), 32'hBEEF);
                    bus.host_req = 1'b0;
                end
            end
            if (bus.phase == 4'd1) chk("mix_vid_load", 32'(bus.vid_load), 32'd1);
        end
        chk("mix_cpu_count",  32'(n_c), 32'd1);
        chk("mix_host_count", 32'(n_h), 32'd2);

        // Reset during the strobe cycle of a CPU write aborts it; held request retries once
        wait_phase(4'd2);
        bus.cpu_we = 1'b1; bus.cpu_adr = 16'h0200; bus.cpu_byte = 1'b0;
        bus.cpu_wdata = 16'h5A5A; bus.cpu_req = 1'b1;
        wait_phase(4'd5);
        chk("abort_we_low", 32'(bus.ram_we_n), 32'd0);
        #1 reset_n = 1'b0;
        #1;
        chk("abort_we_async", 32'(bus.ram_we_n), 32'd1);
        chk("abort_dq_oe",    32'(bus.ram_dq_oe), 32'd0);
        repeat (2) @(negedge clk25);
        chk("abort_no_ack",   32'(bus.cpu_ack), 32'd0);
        reset_n = 1'b1;
        n_ack = 0; ack_ph = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk25);
            if (bus.cpu_ack) begin
                n_ack++;
                ack_ph = int'(bus.phase);
                bus.cpu_req = 1'b0;
            end
        end
        chk("retry_ack_count", 32'(n_ack), 32'd1);
        chk("retry_ack_phase", 32'(ack_ph), 32'd6);
        chk("retry_mem",       32'(sram_rd(18'h00100)), 32'h5A5A);

        // Randomized traffic with one mid-run reset
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk25);
            if (c == 1500) #2 reset_n = 1'b0;
            if (c == 1503) reset_n = 1'b1;
            if (bus.cpu_ack) begin
                if ($urandom_range(0, 2) == 0) bus.cpu_req = 1'b0;
                else rand_cpu();
            end else if (!bus.cpu_req && $urandom_range(0, 3) == 0) begin
                rand_cpu();
                bus.cpu_req = 1'b1;
            end
            if (bus.host_ack) begin
                if ($urandom_range(0, 2) == 0) bus.host_req = 1'b0;
                else rand_host();
            end else if (!bus.host_req && $urandom_range(0, 3) == 0) begin
                rand_host();
                bus.host_req = 1'b1;
            end
            if ($urandom_range(0, 3) == 0) bus.vid_addr = 13'($urandom_range(0, 7));
        end

        @(negedge clk25);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bk_sram_arbiter.md
# bk_sram_arbiter

Time-slot arbiter and sequencer for the single shared 16-bit asynchronous SRAM of the BK-0010 replica. It divides the memory bus into a fixed 16-cycle frame aligned to the pixel clock, and shares it between three requesters: the video shifter, the CPU core and the JTAG debug host. Every frame has one video fetch slot, one CPU slot and two host slots. The block drives all SRAM control, address and byte-lane pins, and returns latched read data with a one-cycle acknowledge per requester.

## Interface
Parameters:
- VIDEO_BASE, 5'b00001, upper five word-address bits prepended to vid_addr.
- ADDR_W, 18, SRAM word-address width.

Ports:
- clk25  in  1  25 MHz pixel/system clock; all logic is on the rising edge.
- reset_n  in  1  one clock; reset is asynchronous and active-low.
- cpu_req  in  1  level request; held high until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_adr  in  16  byte address; word = cpu_adr[15:1].
- cpu_byte  in  1  byte access; the lane is selected by cpu_adr[0].
- cpu_wdata  in  16  write data.
- cpu_rdata  out  16  read data; valid while cpu_ack = 1 and held until the next CPU read.
- cpu_ack  out  1  one-cycle completion pulse.
- host_req, host_we  in  1  host request and write select; same rules as the CPU pair.
- host_addr  in  ADDR_W  host word address.
- host_wdata  in  16  host write data.
- host_rdata  out  16  host read data.
- host_ack  out  1  one-cycle completion pulse.
- vid_addr  in  13  video word address ({row, column}).
- vid_data  out  16  fetched video word.
- vid_load  out  1  one-cycle load strobe to the shifter.
- phase  out  4  current frame slot.
- ram_addr  out  ADDR_W  SRAM word address.
- ram_dq_o  out  16  write data to the SRAM.
- ram_dq_oe  out  1  enable for the data-pin output driver.
- ram_dq_i  in  16  read data from the SRAM.
- ram_oe_n, ram_we_n, ram_lb_n, ram_ub_n  out  1  SRAM strobes, all active low.

## Operation
- phase is a free-running 4-bit counter that wraps 15→0. The state machine is a pure function of phase plus the requests sampled at slot start.
- States are IDLE, VID, CPU_SETUP, CPU_STROBE, HOST_SETUP and HOST_STROBE.
- Phase 0 → VID, unconditionally.
  - ram_addr = {VIDEO_BASE, vid_addr}; ram_oe_n = 0; both lanes enabled.
- Phase 4, if cpu_req = 1 → CPU_SETUP, then phase 5 → CPU_STROBE.
  - ram_addr = {0, cpu_adr[15:1]}.
  - Reads hold ram_oe_n = 0 for both cycles.
  - Writes hold ram_dq_oe = 1 with ram_dq_o = cpu_wdata for both cycles; ram_we_n = 0 only in CPU_STROBE.
- Phases 8 and 12, if host_req = 1 → HOST_SETUP, then phases 9 and 13 → HOST_STROBE, with the same sequencing as the CPU. Host accesses always use both lanes.
- CPU byte lanes:
  - ram_lb_n = cpu_byte & cpu_adr[0].
  - ram_ub_n = cpu_byte & ~cpu_adr[0].
- All other phases, and slots whose request is low, are IDLE.
  - ram_oe_n = ram_we_n = 1, ram_dq_oe = 0, lanes = 1, ram_addr = video address.
- Requests are levels. Each slot that starts with its request high performs exactly one access. A requester that keeps req high after its ack gets a new access at its next slot.
- cpu_we, cpu_adr and cpu_wdata (and the host equivalents) must stay stable from slot start until the ack.
- No priority logic is needed: slots are disjoint. Simultaneous CPU and host requests are served in their own windows in the same frame.

## Timing
- Reset values:
  - phase = 0, state = IDLE.
  - ram_oe_n = ram_we_n = ram_lb_n = ram_ub_n = 1, ram_dq_oe = 0.
  - All acks and vid_load = 0; all rdata outputs and vid_data = 0.
- An asserted reset mid-access aborts it immediately: strobes go inactive asynchronously and no ack is issued. An abandoned request restarts at the first valid slot after release.
- Video:
  - ram_dq_i is registered into vid_data at the end of phase 0.
  - vid_load = 1 during phase 1.
- CPU:
  - Read data is registered into cpu_rdata at the end of phase 5.
  - cpu_ack = 1 during phase 6.
  - Latency from slot start is 2 cycles; worst case from request is 18 cycles.
- Host: rdata is registered at the end of phase 9/13, and host_ack = 1 during phase 10/14.
- Strobes and ram_addr are registered outputs, so there are no glitches.
- ram_we_n falls one cycle after address and data are stable, and rises at the same edge at which the access ends.

## Test plan
- Reset release, no requests → phase counts 0..15 and wraps. ram_oe_n is 0 only in phase 0; vid_load pulses in phase 1 with vid_data equal to the SRAM model word at {00001, vid_addr}.
- CPU word read of 16'o100000, with the model holding 16'h1234 → one-cycle cpu_ack in phase 6 with cpu_rdata = 16'h1234; ram_addr = 18'h04000 in phases 4–5.
- CPU byte write of 16'h00AB to odd address 16'h0101 → ram_we_n = 0 only in phase 5, ram_lb_n = 1, ram_ub_n = 0, and the model's upper byte = 8'h00.
- CPU and host requesting in the same frame: host write 16'hBEEF to 18'h08000 and host read back → CPU served at phase 6, host write acked at phase 10, read acked at phase 14 with 16'hBEEF; the video fetch is unaffected.
- reset_n pulsed low during CPU_STROBE of a write → ram_we_n goes high asynchronously and no cpu_ack is issued. After release, with the request still held high, the write completes once with ack at phase 6.
